// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding, timing defaults and odd-parity helper
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, RTS, REQ, START, DATA, ACK, WAIT_IDLE} ps2_state_t;
  localparam int INHIBIT_CYC_DEF = 5000;
  localparam int FILTER_LEN_DEF = 8;
  localparam int TIMEOUT_CYC_DEF = 750000;
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: synchronises the PS/2 clock and accepts a new level only after
// FILTER_LEN consecutive equal samples; fall pulses for one cycle on 1->0.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c_in,
  output logic level,
  output logic fall
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic c_m, c_s, hit;
  logic [CW-1:0] cnt;
  assign hit = (c_s != level) && cnt == CW'(FILTER_LEN - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      c_m <= 1'b1;
      c_s <= 1'b1;
      level <= 1'b1;
      cnt <= '0;
      fall <= 1'b0;
    end else begin
      {c_s, c_m} <= {c_m, ps2c_in};
      cnt <= (c_s == level || hit) ? '0 : cnt + 1'b1;
      level <= hit ? c_s : level;
      fall <= hit & level;
    end
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter driving open-drain enables
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = INHIBIT_CYC_DEF,
  parameter int FILTER_LEN = FILTER_LEN_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       done_tick,
  output logic       ack_err,
  output logic       timeout_err
);
  localparam int IW = $clog2(INHIBIT_CYC + 1);
  ps2_state_t state, state_n;
  logic [IW-1:0] cnt, cnt_n;
  logic [8:0] sreg, sreg_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic ack_r, ack_r_n, c_oe_n, d_oe_n, idle_n, done_n, ack_err_n, to_err_n;
  logic c_lvl, fall, d_m, d_s, wd_exp, shift;
  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk(clk),
    .reset(reset),
    .ps2c_in(ps2c_in),
    .level(c_lvl),
    .fall(fall)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) {d_s, d_m} <= 2'b11;
    else {d_s, d_m} <= {d_m, ps2d_in};
`ifdef PS2_TX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC);
  logic [WW-1:0] wd;
  logic wd_run;
  assign wd_run = state inside {START, DATA, ACK, WAIT_IDLE};
  assign wd_exp = wd_run && !fall && wd == WW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) wd <= '0;
    else wd <= (wd_run && !fall) ? wd + 1'b1 : '0;
`else
  assign wd_exp = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      sreg <= '0;
      bit_cnt <= '0;
      ack_r <= 1'b0;
      ps2c_oe <= 1'b0;
      ps2d_oe <= 1'b0;
      tx_idle <= 1'b1;
      done_tick <= 1'b0;
      ack_err <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sreg <= sreg_n;
      bit_cnt <= bit_cnt_n;
      ack_r <= ack_r_n;
      ps2c_oe <= c_oe_n;
      ps2d_oe <= d_oe_n;
      tx_idle <= idle_n;
      done_tick <= done_n;
      ack_err <= ack_err_n;
      timeout_err <= to_err_n;
    end
  always_comb begin
    state_n = state;
    if (wd_exp) state_n = IDLE;
    else
      case (state)
        IDLE:      if (wr_ps2) state_n = RTS;
        RTS:       if (cnt == IW'(INHIBIT_CYC - 1)) state_n = REQ;
        REQ:       state_n = START;
        START:     if (fall) state_n = DATA;
        DATA:      if (fall && bit_cnt == 4'd8) state_n = ACK;
        ACK:       if (fall) state_n = WAIT_IDLE;
        WAIT_IDLE: if (c_lvl && d_s) state_n = IDLE;
        default:   state_n = IDLE;
      endcase
  end
  always_comb begin
    shift = fall && state_n == DATA;
    cnt_n = (state == RTS) ? cnt + 1'b1 : '0;
    sreg_n = (state == IDLE && wr_ps2) ? {odd_parity(din), din} : shift ? {1'b0, sreg[8:1]} : sreg;
    bit_cnt_n = (state == START) ? '0 : shift ? bit_cnt + 1'b1 : bit_cnt;
    ack_r_n = (state == ACK && fall) ? d_s : ack_r;
    c_oe_n = state_n inside {RTS, REQ};
    d_oe_n = (state_n inside {REQ, START}) ? 1'b1 : (state_n == DATA) ? (fall ? ~sreg[0] : ps2d_oe) : 1'b0;
    idle_n = state_n == IDLE;
    done_n = state != IDLE && state_n == IDLE;
    ack_err_n = done_n ? ack_r & ~wd_exp : ack_err;
    to_err_n = done_n ? wd_exp : timeout_err;
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: PS/2 device model on open-drain lines plus a cycle-level model of the host outputs
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH = 5000;
  localparam int FL = 8;
  localparam int HALF = 40;
`ifdef PS2_TX_TIMEOUT_EN
  localparam int TO = 3000;
`else
  localparam int TO = 750000;
`endif
  logic clk = 1'b0, reset = 1'b0, wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic dev_c = 1'b1, dev_d = 1'b1;
  logic ps2c_line, ps2d_line;
  logic ps2c_oe, ps2d_oe, tx_idle, done_tick, ack_err, timeout_err;
  int n_chk = 0, n_fail = 0, n_done = 0, dev_falls = 0, c_len = 0, last_c_len = 0, m_cnt = 0;
  bit dev_fin = 1'b0, dev_ack = 1'b0, m_busy = 1'b0, m_to_mode = 1'b0;
  logic m_ack = 1'b0, m_to = 1'b0;

  assign ps2c_line = ps2c_oe ? 1'b0 : dev_c;
  assign ps2d_line = ps2d_oe ? 1'b0 : dev_d;

  ps2_host_tx #(.INHIBIT_CYC(INH), .FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk),
    .reset(reset),
    .wr_ps2(wr_ps2),
    .din(din),
    .ps2c_in(ps2c_line),
    .ps2d_in(ps2d_line),
    .ps2c_oe(ps2c_oe),
    .ps2d_oe(ps2d_oe),
    .tx_idle(tx_idle),
    .done_tick(done_tick),
    .ack_err(ack_err),
    .timeout_err(timeout_err)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      m_busy = 1'b0;
      m_ack = 1'b0;
      m_to = 1'b0;
    end else if (m_busy) begin
      m_cnt++;
      if (m_to_mode) chk("timeout_done", done_tick, m_cnt == INH + 1 + TO);
      if (done_tick) begin
        if (!m_to_mode) chk("done_allowed", dev_fin, 1'b1);
        m_busy = 1'b0;
        m_ack = m_to_mode ? 1'b0 : !dev_ack;
        m_to = m_to_mode;
        n_done++;
      end
    end else begin
      chk("spurious_done", done_tick, 1'b0);
      if (wr_ps2) begin
        m_busy = 1'b1;
        m_cnt = 0;
      end
    end
    chk("tx_idle", tx_idle, !m_busy);
    chk("ps2c_oe", ps2c_oe, m_busy && m_cnt <= INH);
    if (!m_busy || m_cnt <= INH) chk("ps2d_oe", ps2d_oe, m_busy && m_cnt == INH);
    chk("ack_err", ack_err, m_ack);
    chk("timeout_err", timeout_err, m_to);
    if (ps2c_oe) c_len++;
    else if (c_len != 0) begin
      last_c_len = c_len;
      c_len = 0;
    end
  end

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    din = d;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
  endtask

  task automatic device_xfer(input int n_falls, input bit ack, input bit glitch, output logic [10:0] frame);
    int t;
    frame = '0;
    dev_fin = 1'b0;
    dev_ack = ack;
    t = 0;
    while (!(!ps2c_oe && ps2d_oe) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("req_seen", t < 20000, 1'b1);
    if (t >= 20000) return;
    repeat (20) @(negedge clk);
    if (glitch) begin
      dev_c = 1'b0;
      repeat (FL - 1) @(negedge clk);
      dev_c = 1'b1;
      repeat (20) @(negedge clk);
    end
    frame[0] = ps2d_line;
    for (int k = 1; k <= n_falls; k++) begin
      dev_c = 1'b0;
      dev_falls = k;
      repeat (HALF) @(negedge clk);
      if (k <= 10) frame[k] = ps2d_line;
      dev_c = 1'b1;
      if (k == 11) begin
        dev_d = 1'b1;
        dev_fin = 1'b1;
      end
      repeat (HALF) @(negedge clk);
      if (k == 10 && ack) dev_d = 1'b0;
    end
  endtask

  task automatic wait_done(input int k);
    for (int t = 0; t < 500 && n_done < k; t++) @(negedge clk);
    chk("done_count", n_done, k);
  endtask

  initial begin
    logic [10:0] fr;
    repeat (3) @(negedge clk);
    chk("rst_c_oe", ps2c_oe, 1'b0);
    chk("rst_d_oe", ps2d_oe, 1'b0);
    chk("rst_idle", tx_idle, 1'b1);
    chk("rst_done", done_tick, 1'b0);
    chk("rst_ack_err", ack_err, 1'b0);
    chk("rst_to_err", timeout_err, 1'b0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    start_tx(8'h5A);
    device_xfer(11, 1'b1, 1'b0, fr);
    wait_done(1);
    chk("t1_frame", fr, 11'h6B4);
    chk("t1_frame_model", fr, frame_of(8'h5A));
    chk("t1_ack_err", ack_err, 1'b0);
    chk("t3_inhibit_len", last_c_len, 5001);
    start_tx(8'h00);
    device_xfer(11, 1'b0, 1'b0, fr);
    wait_done(2);
    chk("t2_frame", fr, 11'h600);
    chk("t2_frame_model", fr, frame_of(8'h00));
    chk("t2_ack_err", ack_err, 1'b1);
    start_tx(8'hC3);
    dev_falls = 0;
    fork
      device_xfer(11, 1'b1, 1'b1, fr);
      begin
        for (int t = 0; t < 20000 && dev_falls < 3; t++) @(negedge clk);
        din = 8'hFF;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
      end
    join
    wait_done(3);
    chk("t4_frame", fr, 11'h786);
    chk("t4_frame_model", fr, frame_of(8'hC3));
    chk("t4_ack_err", ack_err, 1'b0);
    start_tx(8'h00);
    device_xfer(5, 1'b0, 1'b0, fr);
    chk("t5_pre_d_oe", ps2d_oe, 1'b1);
    chk("t5_pre_idle", tx_idle, 1'b0);
    reset = 1'b0;
    #1;
    chk("t5_c_oe", ps2c_oe, 1'b0);
    chk("t5_d_oe", ps2d_oe, 1'b0);
    chk("t5_idle", tx_idle, 1'b1);
    chk("t5_done", done_tick, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (50) @(negedge clk);
    chk("t5_no_done", n_done, 3);
    start_tx(8'h01);
    device_xfer(11, 1'b1, 1'b0, fr);
    wait_done(4);
    chk("t5_frame", fr, 11'h402);
    chk("t5_frame_model", fr, frame_of(8'h01));
`ifdef PS2_TX_TIMEOUT_EN
    m_to_mode = 1'b1;
    start_tx(8'hA5);
    for (int t = 0; t < INH + TO + 200 && n_done < 5; t++) @(negedge clk);
    chk("t6_done_count", n_done, 5);
    chk("t6_to_err", timeout_err, 1'b1);
    chk("t6_ack_err", ack_err, 1'b0);
    chk("t6_c_oe", ps2c_oe, 1'b0);
    chk("t6_d_oe", ps2d_oe, 1'b0);
    m_to_mode = 1'b0;
`endif
    repeat (10) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
